cache_line_refill_ctrl: RTL

- Miss-handling sequencer between the data cache line array and the single-port data block RAM.
- On a cache miss it writes back the dirty victim line word by word, then reads the requested line word by word, assembles it into a fill buffer, and hands it to the cache with a one-cycle done pulse.
- Drives the processor stall for the whole transfer.
- Replaces the ad-hoc ACCESS_MEMORY/UPDATE_CACHE sequencing inside the cached data memory.

---
 rtl/cache_line_refill_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/cache_line_refill_ctrl.sv
// Cache line refill sequencer: writes back a dirty victim line, then fetches the
// requested line from the single-port data RAM into a fill buffer.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | waiting for a miss; miss_ready=1
//   WRITEBACK | one victim word written to RAM per cycle
//   READ      | one fill word address issued per cycle, previous word captured
//   DRAIN     | capture the last word returned by the RAM
//   DONE      | one-cycle done pulse; cache writes fill_data
module cache_line_refill_ctrl #(
  parameter int LINE_WORDS        = 4,
  parameter int LINE_ADDR_W       = 10,
  parameter int RAM_ADDR_W        = 10,
  parameter int ADDR_OFFSET_WORDS = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     miss_valid,
  output logic                     miss_ready,
  input  logic                     victim_dirty,
  input  logic [LINE_ADDR_W-1:0]   victim_addr,
  input  logic [LINE_WORDS*32-1:0] victim_data,
  input  logic [LINE_ADDR_W-1:0]   fill_addr,
  output logic [LINE_WORDS*32-1:0] fill_data,
  output logic                     done,
  output logic                     stall,
  output logic                     busy,
  output logic [RAM_ADDR_W-1:0]    ram_addr,
  output logic                     ram_we,
  output logic [31:0]              ram_wdata,
  input  logic [31:0]              ram_rdata
);

  localparam int CNT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int WA_W  = LINE_ADDR_W + CNT_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_WORDS - 1);
  localparam logic [WA_W-1:0]  WA_OFFSET = WA_W'(ADDR_OFFSET_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITEBACK,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [LINE_ADDR_W-1:0] victim_addr_q;
  logic [LINE_ADDR_W-1:0] fill_addr_q;
  logic [31:0]            victim_w [LINE_WORDS];
  logic [31:0]            fill_w   [LINE_WORDS];
  logic                   done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      victim_addr_q <= '0;
      fill_addr_q   <= '0;
      done_q        <= 1'b0;
      for (int k = 0; k < LINE_WORDS; k++) begin
        victim_w[k] <= '0;
        fill_w[k]   <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (miss_valid) begin
            victim_addr_q <= victim_addr;
            fill_addr_q   <= fill_addr;
            for (int k = 0; k < LINE_WORDS; k++) begin
              victim_w[k] <= victim_data[k*32 +: 32];
            end
            cnt   <= '0;
            state <= victim_dirty ? S_WRITEBACK : S_READ;
          end
        end
        S_WRITEBACK: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            state <= S_READ;
          end
        end
        S_READ: begin
          // RAM data lags the address by one cycle, so word i-1 lands now
          if (cnt != '0) begin
            fill_w[cnt - CNT_W'(1)] <= ram_rdata;
          end
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          fill_w[CNT_LAST] <= ram_rdata;
          done_q           <= 1'b1;
          state            <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  logic [LINE_ADDR_W-1:0] line_sel;
  logic                   xfer;

  always_comb begin
    line_sel = (state == S_WRITEBACK) ? victim_addr_q : fill_addr_q;
    xfer     = (state == S_WRITEBACK) || (state == S_READ);
    // modular wrap below the offset is intentional
    ram_addr  = xfer ? RAM_ADDR_W'({line_sel, cnt} - WA_OFFSET) : '0;
    ram_we    = (state == S_WRITEBACK);
    ram_wdata = (state == S_WRITEBACK) ? victim_w[cnt] : '0;
  end

  always_comb begin
    fill_data = '0;
    for (int k = 0; k < LINE_WORDS; k++) begin
      fill_data[k*32 +: 32] = fill_w[k];
    end
  end

  // stall drops in DONE so the core resumes while the line is written
  assign stall      = ((state == S_IDLE) && miss_valid) || (state == S_WRITEBACK) ||
                      (state == S_READ) || (state == S_DRAIN);
  assign busy       = (state != S_IDLE);
  assign miss_ready = (state == S_IDLE);
  assign done       = done_q;

endmodule
